// File: rtl/glitch_sweep_ctrl_if.sv
// glitch_sweep_ctrl_if: control/status and engine handshake bundle for the sweep sequencer
interface glitch_sweep_ctrl_if;
  logic start;
  logic abort;
  logic engine_done;
  logic hit;
  logic arm;
  logic [31:0] delay_count;
  logic [31:0] gwidth_count;
  logic busy;
  logic finished;
  logic found;
  logic [31:0] hit_delay;
  logic [31:0] hit_width;
  logic [31:0] attempt_count;
  logic timeout;
  modport master (
    output start, abort, engine_done, hit,
    input  arm, delay_count, gwidth_count, busy, finished, found,
    input  hit_delay, hit_width, attempt_count, timeout
  );
  modport slave (
    input  start, abort, engine_done, hit,
    output arm, delay_count, gwidth_count, busy, finished, found,
    output hit_delay, hit_width, attempt_count, timeout
  );
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: delay x width glitch sweep sequencer; GLITCH_SWEEP_TIMEOUT_EN adds a WAIT_DONE watchdog
module glitch_sweep_ctrl #(
  parameter logic [31:0] DELAY_MIN     = 32'd1000,
  parameter logic [31:0] DELAY_MAX     = 32'd100000,
  parameter logic [31:0] DELAY_STEP    = 32'd1000,
  parameter logic [31:0] WIDTH_MIN     = 32'd2,
  parameter logic [31:0] WIDTH_MAX     = 32'd204,
  parameter logic [31:0] WIDTH_STEP    = 32'd2,
  parameter logic [15:0] REPEAT        = 16'd4,
  parameter logic [31:0] SETTLE_CYCLES = 32'd1024,
`ifdef GLITCH_SWEEP_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd408_000_000,
`endif
  parameter bit          STOP_ON_HIT   = 1'b1
) (
  input logic clk,
  input logic rst,
  glitch_sweep_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT_DONE, SETTLE, CHECK, NEXT, DONE} state_t;
  localparam bit DEGEN = (WIDTH_MIN > WIDTH_MAX) || (DELAY_MIN > DELAY_MAX);
  state_t state_q, state_n;
  logic arm_q, busy_q, fin_q, found_q, found_n;
  logic [31:0] delay_q, delay_n, width_q, width_n, hd_q, hd_n, hw_q, hw_n;
  logic [31:0] att_q, att_n, att_inc, set_q, set_n;
  logic [15:0] rep_q, rep_n;
  logic [32:0] w_nx, d_nx;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
  logic [31:0] wd_q, wd_n;
  logic to_q, to_n;
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
  assign att_inc = &att_q ? att_q : att_q + 32'd1;
  assign w_nx = {1'b0, width_q} + {1'b0, WIDTH_STEP};
  assign d_nx = {1'b0, delay_q} + {1'b0, DELAY_STEP};
  assign bus.arm = arm_q;
  assign bus.busy = busy_q;
  assign bus.finished = fin_q;
  assign bus.found = found_q;
  assign bus.delay_count = delay_q;
  assign bus.gwidth_count = width_q;
  assign bus.hit_delay = hd_q;
  assign bus.hit_width = hw_q;
  assign bus.attempt_count = att_q;
  // state and datapath registers; arm/busy/finished are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      arm_q <= 1'b0;
      busy_q <= 1'b0;
      fin_q <= 1'b0;
      found_q <= 1'b0;
      delay_q <= DELAY_MIN;
      width_q <= WIDTH_MIN;
      hd_q <= '0;
      hw_q <= '0;
      att_q <= '0;
      set_q <= '0;
      rep_q <= '0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
      wd_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      arm_q <= state_n == ARM;
      busy_q <= state_n inside {LOAD, ARM, WAIT_DONE, SETTLE, CHECK, NEXT};
      fin_q <= state_n == DONE;
      found_q <= found_n;
      delay_q <= delay_n;
      width_q <= width_n;
      hd_q <= hd_n;
      hw_q <= hw_n;
      att_q <= att_n;
      set_q <= set_n;
      rep_q <= rep_n;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
      wd_q <= wd_n;
      to_q <= to_n;
`endif
    end
  end
  // next-state and datapath updates; abort overrides everything and freezes the status registers
  always_comb begin
    state_n = state_q;
    found_n = found_q;
    delay_n = delay_q;
    width_n = width_q;
    hd_n = hd_q;
    hw_n = hw_q;
    att_n = att_q;
    set_n = set_q;
    rep_n = rep_q;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
    wd_n = wd_q;
    to_n = to_q;
`endif
    if (bus.abort) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_n = LOAD;
            found_n = 1'b0;
            att_n = '0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
            to_n = 1'b0;
`endif
          end
        end
        LOAD: begin
          state_n = ARM;
          delay_n = DELAY_MIN;
          width_n = WIDTH_MIN;
          rep_n = '0;
        end
        ARM: begin
          state_n = WAIT_DONE;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
          wd_n = '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.engine_done) begin
            state_n = SETTLE_CYCLES == 32'd0 ? CHECK : SETTLE;
            set_n = '0;
          end
`ifdef GLITCH_SWEEP_TIMEOUT_EN
          else if ({1'b0, wd_q} + 33'd1 >= {1'b0, TIMEOUT_CYCLES}) begin
            state_n = NEXT;
            to_n = 1'b1;
            att_n = att_inc;
          end else begin
            wd_n = wd_q + 32'd1;
          end
`endif
        end
        SETTLE: begin
          state_n = set_q == SETTLE_CYCLES - 32'd1 ? CHECK : SETTLE;
          set_n = set_q + 32'd1;
        end
        CHECK: begin
          att_n = att_inc;
          state_n = bus.hit && STOP_ON_HIT ? DONE : NEXT;
          if (bus.hit) begin
            found_n = 1'b1;
            hd_n = delay_q;
            hw_n = width_q;
          end
        end
        NEXT: begin
          if ({1'b0, rep_q} + 17'd1 < {1'b0, REPEAT}) begin
            rep_n = rep_q + 16'd1;
            state_n = ARM;
          end else begin
            rep_n = '0;
            if (DEGEN) begin
              state_n = DONE;
            end else if (w_nx <= {1'b0, WIDTH_MAX}) begin
              width_n = w_nx[31:0];
              state_n = ARM;
            end else begin
              width_n = WIDTH_MIN;
              state_n = d_nx <= {1'b0, DELAY_MAX} ? ARM : DONE;
              delay_n = d_nx <= {1'b0, DELAY_MAX} ? d_nx[31:0] : delay_q;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb_glitch_sweep_ctrl: directed checks of sweep order, stop/continue on hit, abort, overflow, degenerate range, watchdog
module tb_glitch_sweep_ctrl;
  logic clk, rst;
  int checks = 0;
  int failures = 0;
  int ca = 0, cb = 0, cc = 0, cd = 0;
  int n;
  logic hit_en;
  logic [63:0] pts[$];
  logic [63:0] exp_pts [6];

  glitch_sweep_ctrl_if a();
  glitch_sweep_ctrl_if b();
  glitch_sweep_ctrl_if c();
  glitch_sweep_ctrl_if d();

  glitch_sweep_ctrl #(.DELAY_MIN(32'd10), .DELAY_MAX(32'd30), .DELAY_STEP(32'd10),
    .WIDTH_MIN(32'd2), .WIDTH_MAX(32'd4), .WIDTH_STEP(32'd2), .REPEAT(16'd1),
    .SETTLE_CYCLES(32'd0), .STOP_ON_HIT(1'b1)) u_a (.clk(clk), .rst(rst), .bus(a));
  glitch_sweep_ctrl #(.DELAY_MIN(32'd10), .DELAY_MAX(32'd30), .DELAY_STEP(32'd10),
    .WIDTH_MIN(32'd2), .WIDTH_MAX(32'd4), .WIDTH_STEP(32'd2), .REPEAT(16'd2),
    .SETTLE_CYCLES(32'd0), .STOP_ON_HIT(1'b0)) u_b (.clk(clk), .rst(rst), .bus(b));
  glitch_sweep_ctrl #(.DELAY_MIN(32'hFFFF_FFE0), .DELAY_MAX(32'hFFFF_FFF0), .DELAY_STEP(32'h20),
    .WIDTH_MIN(32'd2), .WIDTH_MAX(32'd4), .WIDTH_STEP(32'd2), .REPEAT(16'd1),
    .SETTLE_CYCLES(32'd0), .STOP_ON_HIT(1'b1)) u_c (.clk(clk), .rst(rst), .bus(c));
  glitch_sweep_ctrl #(.DELAY_MIN(32'd10), .DELAY_MAX(32'd30), .DELAY_STEP(32'd10),
    .WIDTH_MIN(32'd6), .WIDTH_MAX(32'd4), .WIDTH_STEP(32'd2), .REPEAT(16'd2),
    .SETTLE_CYCLES(32'd3), .STOP_ON_HIT(1'b1)) u_d (.clk(clk), .rst(rst), .bus(d));

`ifdef GLITCH_SWEEP_TIMEOUT_EN
  glitch_sweep_ctrl_if t();
  glitch_sweep_ctrl #(.DELAY_MIN(32'd10), .DELAY_MAX(32'd30), .DELAY_STEP(32'd10),
    .WIDTH_MIN(32'd2), .WIDTH_MAX(32'd4), .WIDTH_STEP(32'd2), .REPEAT(16'd1),
    .SETTLE_CYCLES(32'd0), .TIMEOUT_CYCLES(32'd100), .STOP_ON_HIT(1'b1)) u_t (.clk(clk), .rst(rst), .bus(t));
  assign t.engine_done = 1'b0;
  assign t.hit = 1'b1;
`endif

  assign a.hit = hit_en && a.delay_count == 32'd20 && a.gwidth_count == 32'd4;
  assign b.hit = b.delay_count == 32'd10 && b.gwidth_count == 32'd2;
  assign c.hit = 1'b0;
  assign d.hit = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ca = a.arm ? 3 : (ca > 0 ? ca - 1 : 0);
    a.engine_done = ca == 1;
    if (a.arm) pts.push_back({a.delay_count, a.gwidth_count});
  end
  always @(negedge clk) begin
    cb = b.arm ? 3 : (cb > 0 ? cb - 1 : 0);
    b.engine_done = cb == 1;
  end
  always @(negedge clk) begin
    cc = c.arm ? 3 : (cc > 0 ? cc - 1 : 0);
    c.engine_done = cc == 1;
  end
  always @(negedge clk) begin
    cd = d.arm ? 3 : (cd > 0 ? cd - 1 : 0);
    d.engine_done = cd == 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_pts = '{{32'd10, 32'd2}, {32'd10, 32'd4}, {32'd20, 32'd2},
                {32'd20, 32'd4}, {32'd30, 32'd2}, {32'd30, 32'd4}};
    rst = 1'b1;
    hit_en = 1'b0;
    a.start = 0; a.abort = 0; b.start = 0; b.abort = 0;
    c.start = 0; c.abort = 0; d.start = 0; d.abort = 0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
    t.start = 0; t.abort = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_arm", a.arm, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_finished", a.finished, 0);
    chk("rst_found", a.found, 0);
    chk("rst_timeout", a.timeout, 0);
    chk("rst_delay", a.delay_count, 10);
    chk("rst_width", a.gwidth_count, 2);
    chk("rst_hit_delay", a.hit_delay, 0);
    chk("rst_hit_width", a.hit_width, 0);
    chk("rst_attempts", a.attempt_count, 0);
    rst = 1'b0;
    @(negedge clk); a.start = 1;
    @(negedge clk); a.start = 0;
    chk("load_busy", a.busy, 1);
    chk("load_arm", a.arm, 0);
    @(negedge clk);
    chk("arm_pulse", a.arm, 1);
    @(negedge clk);
    chk("arm_one_cycle", a.arm, 0);
    for (int i = 0; i < 500 && !a.finished; i++) @(negedge clk);
    chk("full_finished", a.finished, 1);
    chk("full_busy", a.busy, 0);
    chk("full_attempts", a.attempt_count, 6);
    chk("full_found", a.found, 0);
    chk("full_arm_count", pts.size(), 6);
    for (int i = 0; i < 6; i++) chk("full_point", pts[i], exp_pts[i]);
    hit_en = 1'b1;
    @(negedge clk); a.start = 1;
    @(negedge clk); a.start = 0;
    for (int i = 0; i < 500 && !a.finished; i++) @(negedge clk);
    chk("stop_finished", a.finished, 1);
    chk("stop_attempts", a.attempt_count, 4);
    chk("stop_found", a.found, 1);
    chk("stop_hit_delay", a.hit_delay, 20);
    chk("stop_hit_width", a.hit_width, 4);
    chk("stop_delay", a.delay_count, 20);
    chk("stop_width", a.gwidth_count, 4);
    hit_en = 1'b0;
    pts.delete();
    @(negedge clk); a.start = 1;
    @(negedge clk); a.start = 0;
    chk("restart_found_cleared", a.found, 0);
    n = 0;
    for (int i = 0; i < 500 && n < 3; i++) begin
      @(negedge clk);
      if (a.arm) n++;
    end
    chk("abort_reach_arm3", n, 3);
    @(negedge clk); a.abort = 1;
    @(negedge clk); a.abort = 0;
    chk("abort_busy", a.busy, 0);
    chk("abort_arm", a.arm, 0);
    chk("abort_finished", a.finished, 0);
    chk("abort_attempts", a.attempt_count, 2);
    chk("abort_hit_delay_held", a.hit_delay, 20);
    repeat (20) @(negedge clk);
    chk("abort_no_more_arm", pts.size(), 3);
    a.start = 1; a.abort = 1;
    @(negedge clk); a.start = 0; a.abort = 0;
    repeat (5) @(negedge clk);
    chk("start_abort_busy", a.busy, 0);
    chk("start_abort_no_arm", pts.size(), 3);
    pts.delete();
    @(negedge clk); a.start = 1;
    @(negedge clk); a.start = 0;
    repeat (4) @(negedge clk);
    a.start = 1;
    @(negedge clk); a.start = 0;
    for (int i = 0; i < 500 && !a.finished; i++) @(negedge clk);
    chk("busy_start_finished", a.finished, 1);
    chk("busy_start_attempts", a.attempt_count, 6);
    chk("busy_start_arms", pts.size(), 6);
    chk("busy_start_last_point", pts[5], exp_pts[5]);
    @(negedge clk); b.start = 1;
    @(negedge clk); b.start = 0;
    for (int i = 0; i < 1000 && !b.finished; i++) @(negedge clk);
    chk("cont_finished", b.finished, 1);
    chk("cont_attempts", b.attempt_count, 12);
    chk("cont_found", b.found, 1);
    chk("cont_hit_delay", b.hit_delay, 10);
    chk("cont_hit_width", b.hit_width, 2);
    chk("cont_delay", b.delay_count, 30);
    chk("cont_width", b.gwidth_count, 2);
    @(negedge clk); c.start = 1;
    @(negedge clk); c.start = 0;
    for (int i = 0; i < 500 && !c.finished; i++) @(negedge clk);
    chk("ovf_finished", c.finished, 1);
    chk("ovf_attempts", c.attempt_count, 2);
    chk("ovf_delay", c.delay_count, 64'hFFFF_FFE0);
    @(negedge clk); d.start = 1;
    @(negedge clk); d.start = 0;
    for (int i = 0; i < 500 && !d.finished; i++) @(negedge clk);
    chk("degen_finished", d.finished, 1);
    chk("degen_attempts", d.attempt_count, 2);
    chk("degen_width", d.gwidth_count, 6);
    chk("degen_delay", d.delay_count, 10);
    chk("degen_timeout", d.timeout, 0);
`ifdef GLITCH_SWEEP_TIMEOUT_EN
    chk("to_initial", t.timeout, 0);
    @(negedge clk); t.start = 1;
    @(negedge clk); t.start = 0;
    repeat (50) @(negedge clk);
    chk("to_still_waiting", t.attempt_count, 0);
    for (int i = 0; i < 3000 && !t.finished; i++) @(negedge clk);
    chk("to_finished", t.finished, 1);
    chk("to_flag", t.timeout, 1);
    chk("to_attempts", t.attempt_count, 6);
    chk("to_found", t.found, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/glitch_sweep_ctrl.md
Name: glitch_sweep_ctrl

Overview:
- Sequencer that drives a single glitchGen-style engine through a 2-D parameter sweep: trigger delay (outer loop) × glitch width (inner loop).
- Each sweep point is repeated REPEAT times.
- Per attempt: present `delay_count` and `gwidth_count`, pulse `arm`, wait for `engine_done`, wait out a settle window, then sample the target's `hit` flag.
- Sits between the top level (start/abort/status LEDs) and the glitch engine.

Parameters:
- DELAY_MIN, 32'd1000, first delay value (clk cycles)
- DELAY_MAX, 32'd100000, last permitted delay value (inclusive)
- DELAY_STEP, 32'd1000, delay increment; must be ≥1
- WIDTH_MIN, 32'd2, first glitch width (clk cycles)
- WIDTH_MAX, 32'd204, last permitted width value (inclusive)
- WIDTH_STEP, 32'd2, width increment; must be ≥1
- REPEAT, 16'd4, attempts per (delay, width) point; must be ≥1
- SETTLE_CYCLES, 32'd1024, cycles between `engine_done` and the `hit` sample; 0 allowed
- STOP_ON_HIT, 1, 1 = end the sweep on the first hit; 0 = record the hit and continue
- TIMEOUT_CYCLES, 32'd408_000_000, watchdog limit in WAIT_DONE (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a sweep; sampled only in IDLE
- abort  in  1  level/pulse; returns to IDLE from any state
- engine_done  in  1  engine finished its glitch (pulse or level; first high cycle counts)
- hit  in  1  target success indicator; sampled in CHECK only
- arm  out  1  one-cycle pulse telling the engine to arm on its trigger
- delay_count  out  32  current delay to the engine
- gwidth_count  out  32  current width to the engine
- busy  out  1  high from LOAD until the sweep returns to IDLE/DONE
- finished  out  1  high in DONE
- found  out  1  sticky; a hit was seen this sweep
- hit_delay  out  32  delay of the most recent hit
- hit_width  out  32  width of the most recent hit
- attempt_count  out  32  attempts completed this sweep; saturates at all-ones
- timeout  out  1  sticky watchdog flag (0 when the feature is compiled out)

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state = IDLE.
  - `arm`, `busy`, `finished`, `found`, `timeout` = 0.
  - `delay_count` = DELAY_MIN; `gwidth_count` = WIDTH_MIN.
  - `hit_delay`, `hit_width`, `attempt_count` = 0.
  - `rst` mid-sweep has the same effect as reset from idle.
- States: IDLE, LOAD, ARM, WAIT_DONE, SETTLE, CHECK, NEXT, DONE. All outputs are registered.
- IDLE:
  - `start`=1 → LOAD.
  - Clears `found`, `timeout`, `attempt_count`, `finished`.
- LOAD (cycle N+1 after `start` at N):
  - `delay_count`=DELAY_MIN, `gwidth_count`=WIDTH_MIN, repeat counter=0.
  - `busy`=1 from this cycle on.
  - → ARM.
- ARM: `arm`=1 for exactly this one cycle (N+2 for the first attempt) → WAIT_DONE.
- WAIT_DONE:
  - `engine_done`=1 → SETTLE.
  - An `engine_done` that is high during ARM is ignored.
- SETTLE: counts SETTLE_CYCLES cycles, then → CHECK. With SETTLE_CYCLES=0, CHECK follows on the very next cycle.
- CHECK:
  - `attempt_count` += 1 (saturating).
  - If `hit`=1: `found`=1, `hit_delay`/`hit_width` = current values.
  - If `hit`=1 and STOP_ON_HIT=1 → DONE, with `delay_count`/`gwidth_count` left holding the hit point.
  - Otherwise → NEXT.
- NEXT (one cycle):
  - If repeat counter+1 < REPEAT: increment the repeat counter → ARM.
  - Otherwise repeat counter=0 and:
    - Compute `w' = gwidth_count + WIDTH_STEP` in 33 bits.
    - If `w' ≤ WIDTH_MAX` (no overflow): `gwidth_count = w'` → ARM.
    - Else `gwidth_count = WIDTH_MIN`; compute `d' = delay_count + DELAY_STEP` in 33 bits.
      - If `d' ≤ DELAY_MAX`: `delay_count = d'` → ARM.
      - Else → DONE.
  - Values beyond MAX are never presented.
- DONE:
  - `busy`=0, `finished`=1.
  - `found`, `hit_*`, `attempt_count` hold.
  - `start` → LOAD (a new sweep; clears the status registers as IDLE does).
- Abort:
  - `abort`=1 in any state other than IDLE → IDLE next cycle.
  - `arm`=0, `busy`=0, `finished`=0; `found`/`hit_*`/`attempt_count` hold until the next `start`.
- Simultaneous events:
  - `abort` beats `start`.
  - `start` while `busy` is ignored.
  - `rst` beats everything.
- Degenerate ranges: if MIN > MAX in either dimension, the MIN point is still attempted once per REPEAT, then → DONE.

Optional Feature:
- Macro: GLITCH_SWEEP_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without `engine_done`: `timeout`=1 (sticky), the attempt counts as no-hit, and the FSM goes → NEXT. `attempt_count` increments; `hit` is not sampled.
  - The watchdog clears on every entry to WAIT_DONE.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - `timeout` is tied to 0.
  - No watchdog logic is generated.

Test Plan:
- Full sweep: DELAY 10..30 step 10, WIDTH 2..4 step 2, REPEAT=1, SETTLE=0, `hit`=0, `engine_done` 3 cycles after each `arm`.
  - Required: 6 `arm` pulses at points (10,2),(10,4),(20,2),(20,4),(30,2),(30,4).
  - Then `finished`=1, `attempt_count`=6, `found`=0.
- Stop on hit: same config, `hit`=1 only while (20,4) is presented.
  - Required: DONE after 4 attempts, `found`=1, `hit_delay`=20, `hit_width`=4, `delay_count`/`gwidth_count` = 20/4.
- Continue on hit: STOP_ON_HIT=0, REPEAT=2, `hit` at (10,2).
  - Required: 12 attempts, `found`=1, `hit_*`=(10,2).
- Abort/start: `abort` in WAIT_DONE of attempt 3.
  - Required: IDLE next cycle, `busy`=0, `arm` never asserts again.
  - Then `start`+`abort` in the same cycle → stays IDLE.
  - A `start` while `busy` has no effect on the sequence.
- Step overflow: DELAY_MAX=32'hFFFF_FFF0, DELAY_MIN=32'hFFFF_FFE0, DELAY_STEP=32'h20.
  - Required: exactly one delay value attempted, then DONE (no wrap to a small delay).
- With GLITCH_SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=100, `engine_done` never asserted.
  - Required: each attempt advances after 100 cycles, `timeout`=1, sweep completes with `attempt_count`=6.
